// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// in_ready comes straight from a flop, so out_ready never reaches it combinationally.
module pipe_skid_stage #(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_out_valid;
    logic                w_out_valid_next;
    logic                r_in_ready;
    logic                w_in_ready_next;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   w_main_data_next;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [CTRL_W-1:0]   w_main_ctrl_next;
    logic [DATA_W-1:0]   r_skid_data;
    logic [DATA_W-1:0]   w_skid_data_next;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [CTRL_W-1:0]   w_skid_ctrl_next;
    logic                w_accept;
    logic                w_fire;

    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_fire   = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= CTRL_BUBBLE;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_out_valid_next;
            r_in_ready  <= w_in_ready_next;
            r_main_data <= w_main_data_next;
            r_main_ctrl <= w_main_ctrl_next;
            r_skid_data <= w_skid_data_next;
            r_skid_ctrl <= w_skid_ctrl_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_main_data_next = r_main_data;
        w_main_ctrl_next = r_main_ctrl;
        w_skid_data_next = r_skid_data;
        w_skid_ctrl_next = r_skid_ctrl;

        // Flush drops everything; data registers keep stale contents on purpose.
        if (flush) begin
            w_state_next     = EMPTY;
            w_main_ctrl_next = CTRL_BUBBLE;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_next     = ONE;
                        w_main_data_next = in_data;
                        w_main_ctrl_next = in_ctrl;
                    end
                end
                ONE: begin
                    if (w_fire && w_accept) begin
                        w_main_data_next = in_data;
                        w_main_ctrl_next = in_ctrl;
                    end else if (w_fire) begin
                        w_state_next     = EMPTY;
                        w_main_ctrl_next = CTRL_BUBBLE;
                    end else if (w_accept) begin
                        w_state_next     = TWO;
                        w_skid_data_next = in_data;
                        w_skid_ctrl_next = in_ctrl;
                    end
                end
                TWO: begin
                    if (w_fire) begin
                        w_state_next     = ONE;
                        w_main_data_next = r_skid_data;
                        w_main_ctrl_next = r_skid_ctrl;
                    end
                end
                default: begin
                    w_state_next     = EMPTY;
                    w_main_ctrl_next = CTRL_BUBBLE;
                end
            endcase
        end

        w_out_valid_next = (w_state_next != EMPTY);
        w_in_ready_next  = (w_state_next != TWO);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign occ       = r_state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three widths run in lockstep against one occupancy
// model and a FIFO scoreboard of expected entries.
module tb_pipe_skid_stage;

    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [255:0] in_data = '0;
    logic [31:0]  in_ctrl = '0;

    always #5 clk = ~clk;

    logic [127:0] d0_data;
    logic [15:0]  d0_ctrl;
    logic [31:0]  d1_data;
    logic [3:0]   d1_ctrl;
    logic [199:0] d2_data;
    logic [23:0]  d2_ctrl;
    logic [1:0]   occ0, occ1, occ2;
    logic         ir0, ir1, ir2, ov0, ov1, ov2;

    pipe_skid_stage u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data[127:0]), .in_ctrl(in_ctrl[15:0]),
        .out_valid(ov0), .out_ready(out_ready), .out_data(d0_data), .out_ctrl(d0_ctrl), .occ(occ0)
    );

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(4), .CTRL_BUBBLE(4'hA)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data[31:0]), .in_ctrl(in_ctrl[3:0]),
        .out_valid(ov1), .out_ready(out_ready), .out_data(d1_data), .out_ctrl(d1_ctrl), .occ(occ1)
    );

    pipe_skid_stage #(.DATA_W(200), .CTRL_W(24), .CTRL_BUBBLE(24'h5A5A5A)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data[199:0]), .in_ctrl(in_ctrl[23:0]),
        .out_valid(ov2), .out_ready(out_ready), .out_data(d2_data), .out_ctrl(d2_ctrl), .occ(occ2)
    );

    logic [255:0] od_o [NDUT];
    logic [31:0]  oc_o [NDUT];
    logic [1:0]   occ_o[NDUT];
    logic         ir_o [NDUT];
    logic         ov_o [NDUT];

    assign od_o[0] = {128'b0, d0_data};
    assign od_o[1] = {224'b0, d1_data};
    assign od_o[2] = {56'b0, d2_data};
    assign oc_o[0] = {16'b0, d0_ctrl};
    assign oc_o[1] = {28'b0, d1_ctrl};
    assign oc_o[2] = {8'b0, d2_ctrl};
    assign occ_o[0] = occ0;
    assign occ_o[1] = occ1;
    assign occ_o[2] = occ2;
    assign ir_o[0] = ir0;
    assign ir_o[1] = ir1;
    assign ir_o[2] = ir2;
    assign ov_o[0] = ov0;
    assign ov_o[1] = ov1;
    assign ov_o[2] = ov2;

    function automatic logic [255:0] dmask(int k);
        logic [255:0] m;
        m = '1;
        case (k)
            0:       m = m >> 128;
            1:       m = m >> 224;
            default: m = m >> 56;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] cmask(int k);
        logic [31:0] m;
        m = '1;
        case (k)
            0:       m = m >> 16;
            1:       m = m >> 28;
            default: m = m >> 8;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] bubble(int k);
        case (k)
            0:       return 32'h0;
            1:       return 32'hA;
            default: return 32'h5A5A5A;
        endcase
    endfunction

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  c;
    } ent_t;

    ent_t exp_q[$];
    int   m_occ    = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   verbose  = 1'b1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d.occ", k), 256'(occ_o[k]), 256'(m_occ));
            chk($sformatf("dut%0d.in_ready", k), 256'(ir_o[k]), 256'(m_occ != 2));
            chk($sformatf("dut%0d.out_valid", k), 256'(ov_o[k]), 256'(m_occ != 0));
            if (m_occ == 0)
                chk($sformatf("dut%0d.bubble", k), 256'(oc_o[k]), 256'(bubble(k)));
        end
    endtask

    // One clock: score this cycle's handshakes against the model, then check the new state.
    task automatic cycle();
        bit   acc;
        bit   fire;
        ent_t e;
        acc  = in_valid && (m_occ != 2) && !flush;
        fire = out_ready && (m_occ != 0);
        if (fire) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("dut%0d.out_data", k), od_o[k], e.d & dmask(k));
                chk($sformatf("dut%0d.out_ctrl", k), 256'(oc_o[k]), 256'(e.c & cmask(k)));
            end
            if (verbose)
                $display("xfer data=%0h ctrl=%0h", e.d[127:0], e.c[15:0]);
        end
        if (flush)
            exp_q.delete();
        else if (acc)
            exp_q.push_back('{d: in_data, c: in_ctrl});
        m_occ = flush ? 0 : m_occ + int'(acc) - int'(fire);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic drive(input bit v, input logic [255:0] d, input logic [31:0] c,
                         input bit rdy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
        flush     = fl;
        cycle();
    endtask

    initial begin
        logic [255:0] rd;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state();
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("dut%0d.rst_data", k), od_o[k], 256'h0);
        rst = 1'b0;

        // Streaming at full rate
        for (int i = 1; i <= 6; i++)
            drive(1, 256'(i), 32'(i), 1, 0);
        repeat (2) drive(0, 0, 0, 1, 0);

        // Backpressure: A, B fill the stage; C waits on the input
        drive(1, 256'hA, 32'h1, 0, 0);
        drive(1, 256'hB, 32'h2, 0, 0);
        repeat (3) drive(1, 256'hC, 32'h3, 0, 0);
        repeat (2) drive(1, 256'hC, 32'h3, 1, 0);
        repeat (2) drive(0, 0, 0, 1, 0);

        // Bubble after the last entry leaves
        drive(1, 256'h55, 32'h00FF, 0, 0);
        repeat (2) drive(0, 0, 0, 1, 0);

        // Flush while full with a new entry offered; D must never appear
        drive(1, 256'h1, 32'h1, 0, 0);
        drive(1, 256'h2, 32'h2, 0, 0);
        drive(1, 256'hD, 32'hD, 0, 1);
        drive(1, 256'hE, 32'hE, 1, 0);
        repeat (2) drive(0, 0, 0, 1, 0);

        // Flush coinciding with a downstream fire
        drive(1, 256'h6, 32'h6, 0, 0);
        drive(1, 256'h7, 32'h7, 1, 1);
        drive(0, 0, 0, 1, 0);

        // Asynchronous reset mid-cycle while full
        drive(1, 256'h11, 32'h11, 0, 0);
        drive(1, 256'h12, 32'h12, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_occ = 0;
        exp_q.delete();
        check_state();
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("dut%0d.arst_data", k), od_o[k], 256'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) drive(0, 0, 0, 1, 0);

        // Random valid/ready/flush traffic across all three widths
        verbose = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            for (int w = 0; w < 8; w++)
                rd[w*32 +: 32] = $urandom;
            drive($urandom_range(0, 9) < 7, rd, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        repeat (3) drive(0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline-stage register, the successor to the fixed ID/EX latch.
- Carries a data bundle and a control bundle between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer lets in_ready be driven straight from a flop, with no combinational path from out_ready.
- Synchronous flush turns the stage into a bubble: control forced to a safe value, valid cleared. Instantiated between ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 128, width of the datapath bundle (operands, PC, immediates, register indices).
- CTRL_W, 16, width of the control bundle (regWrite, memWrite, ALU op, result select, ...).
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid entry.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of both entries (branch mispredict / hazard clear)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream datapath bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  downstream entry valid; registered
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head-entry datapath bundle; registered
- out_ctrl  out  CTRL_W  head-entry control, or CTRL_BUBBLE when not valid; registered
- occ  out  2  occupancy, 0..2

Behaviour:
- Storage: a main register (drives outputs) and a skid register, each holding data+ctrl. State is one of EMPTY (occ=0), ONE (occ=1), TWO (occ=2).
- Handshakes: accept = in_valid & in_ready & ~flush; fire = out_valid & out_ready.
- Reset (async): state=EMPTY, out_valid=0, in_ready=1, out_ctrl=CTRL_BUBBLE, out_data=0, skid regs=0, occ=0.
- Latency: an accepted entry appears on outputs the next cycle when the stage was EMPTY, or ONE with fire.
- EMPTY:
  - accept -> ONE, main<=in.
  - otherwise stay EMPTY.
- ONE:
  - fire & accept -> ONE, main<=in.
  - fire only -> EMPTY, out_ctrl<=CTRL_BUBBLE, out_data held.
  - accept only -> TWO, skid<=in.
  - neither -> hold.
- TWO (in_ready=0, so no accept is possible):
  - fire -> ONE, main<=skid.
  - otherwise hold.
- in_ready is registered: in_ready_next = (next_state != TWO).
  - Upstream may present in_valid while in_ready=0; nothing is captured.
  - in_data/in_ctrl may change freely until accepted.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_ctrl must not change.
- Flush (sync, highest priority below rst):
  - next state EMPTY, out_valid<=0, out_ctrl<=CTRL_BUBBLE, in_ready<=1, occ<=0.
  - out_data and skid contents are not cleared.
  - A simultaneous accept is dropped. A simultaneous fire still counts downstream that cycle, since the outputs were valid.
- Flush is never part of the asynchronous sensitivity; only rst is asynchronous.
- Reset asserted mid-transfer: all entries are lost immediately and outputs return to their reset values. No entry is delivered after rst deasserts unless newly accepted.
- Ordering: strict FIFO across main and skid; no entry is duplicated or dropped except by flush or rst.
- occ always equals the number of valid entries. occ=2 iff in_ready=0.

Test Plan:
- Streaming: out_ready=1 held, in_valid=1 with in_data=1,2,3,... -> out_data=1,2,3 on consecutive cycles one cycle later; occ=1 steady; in_ready stays 1.
- Backpressure: out_ready=0 after data 0xA accepted, then offer 0xB -> occ=2, in_ready=0 the next cycle; 0xC held on input is not captured. Raise out_ready -> outputs 0xA, 0xB, 0xC in order.
- Bubble: CTRL_BUBBLE=0, in_ctrl=0x00FF accepted, then in_valid=0 with out_ready=1 -> out_ctrl=0x00FF for one cycle, then 0x0000 with out_valid=0.
- Flush in TWO with in_valid=1 (data 0xD) -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occ=0, in_ready=1; 0xD is never output.
- Async reset: assert rst mid-cycle while occ=2 -> outputs immediately at reset values (out_valid=0, in_ready=1, occ=0) without a clock edge.
- Parameter sweep: DATA_W=32/CTRL_W=4 and DATA_W=200/CTRL_W=24 with a random valid/ready scoreboard over 10k cycles -> zero ordering, drop or duplication errors.
